// File: rtl/rf_muldiv_unit.sv
// rtl/rf_muldiv_unit.sv - iterative unsigned multiply/divide unit writing results back to the RF
// Shift-add multiply and restoring divide share one 2*WIDTH accumulator, one bit per cycle.
module rf_muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int INDEX_BITS = 4
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [WIDTH-1:0]      srcA,
    input  logic [WIDTH-1:0]      srcB,
    input  logic [INDEX_BITS-1:0] dstIndex,
    output logic                  busy,
    output logic                  done,
    output logic                  regFileWrEn,
    output logic [INDEX_BITS-1:0] regFileWrIndex,
    output logic [WIDTH-1:0]      regFileWrData
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           count_q, count_d;
    logic [1:0]              op_q, op_d;
    logic [WIDTH-1:0]        a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0]      acc_q, acc_d, step_acc;
    logic                    div0_q, div0_d;
    logic [INDEX_BITS-1:0]   idx_q, idx_d, wr_index_q, wr_index_d;
    logic [WIDTH-1:0]        wr_data_q, wr_data_d;
    logic [WIDTH:0]          mul_sum, rem_shift, rem_next;
    logic                    rem_ge;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            div0_q     <= 1'b0;
            idx_q      <= '0;
            wr_index_q <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            div0_q     <= div0_d;
            idx_q      <= idx_d;
            wr_index_q <= wr_index_d;
            wr_data_q  <= wr_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (count_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Multiply: accumulator is {product_hi, multiplier}, shifted right each step.
    // Divide: accumulator is {remainder, dividend/quotient}, shifted left each step.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
        rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_ge    = (rem_shift >= {1'b0, b_q});
        rem_next  = rem_ge ? (rem_shift - {1'b0, b_q}) : rem_shift;
        if (op_q[1]) begin
            step_acc = {rem_next[WIDTH-1:0], acc_q[WIDTH-2:0], rem_ge};
        end else if (acc_q[0]) begin
            step_acc = {mul_sum, acc_q[WIDTH-1:1]};
        end else begin
            step_acc = {1'b0, acc_q[2*WIDTH-1:1]};
        end
    end

    // Divide-by-zero runs a single RUN cycle with a forced result so done lands one edge later.
    always_comb begin
        count_d    = count_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        div0_d     = div0_q;
        idx_d      = idx_q;
        wr_index_d = wr_index_q;
        wr_data_d  = wr_data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = srcA;
                    b_d     = srcB;
                    idx_d   = dstIndex;
                    div0_d  = op[1] && (srcB == '0);
                    count_d = (op[1] && (srcB == '0)) ? '0 : CW'(WIDTH - 1);
                    acc_d   = {{WIDTH{1'b0}}, (op[1] ? srcA : srcB)};
                end
            end
            S_RUN: begin
                acc_d = step_acc;
                if (count_q != '0) begin
                    count_d = count_q - 1'b1;
                end else begin
                    wr_index_d = idx_q;
                    if (div0_q) begin
                        wr_data_d = op_q[0] ? a_q : {WIDTH{1'b1}};
                    end else begin
                        wr_data_d = op_q[0] ? step_acc[2*WIDTH-1:WIDTH] : step_acc[WIDTH-1:0];
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy           = (state_q != S_IDLE);
        done           = (state_q == S_DONE);
        regFileWrEn    = (state_q == S_DONE);
        regFileWrIndex = wr_index_q;
        regFileWrData  = wr_data_q;
    end

endmodule

// File: tb/tb_rf_muldiv_unit.sv
// tb/tb_rf_muldiv_unit.sv - directed self-checking bench for rf_muldiv_unit
module tb_rf_muldiv_unit;

    logic        clk;
    logic        resetN;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic [3:0]  dstIndex;
    logic        busy;
    logic        done;
    logic        regFileWrEn;
    logic [3:0]  regFileWrIndex;
    logic [31:0] regFileWrData;

    int total;
    int bad;

    rf_muldiv_unit #(.WIDTH(32), .INDEX_BITS(4)) dut (
        .clk            (clk),
        .resetN         (resetN),
        .start          (start),
        .op             (op),
        .srcA           (srcA),
        .srcB           (srcB),
        .dstIndex       (dstIndex),
        .busy           (busy),
        .done           (done),
        .regFileWrEn    (regFileWrEn),
        .regFileWrIndex (regFileWrIndex),
        .regFileWrData  (regFileWrData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one operation, scrambles the inputs after the start edge, then watches 40 cycles.
    // lat is the number of edges after the start edge until the first write is seen.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] idx, output int lat, output logic [31:0] data,
                         output logic [3:0] windex, output int writes);
        @(negedge clk);
        start = 1'b1; op = o; srcA = a; srcB = b; dstIndex = idx;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; srcA = $urandom; srcB = $urandom; dstIndex = 4'($urandom);
        op = 2'($urandom);
        lat = -1; writes = 0; data = '0; windex = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (regFileWrEn) begin
                writes++;
                if (lat < 0) begin
                    lat = k; data = regFileWrData; windex = regFileWrIndex;
                end
            end
        end
    endtask

    task automatic test_reset();
        resetN = 1'b1; start = 1'b0; op = '0; srcA = '0; srcB = '0; dstIndex = '0;
        #3 resetN = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
        total++; if (regFileWrEn !== 1'b0) begin bad++; $display("FAIL reset_wren got=%0b exp=0", regFileWrEn); end
        total++; if (regFileWrIndex !== 4'd0) begin bad++; $display("FAIL reset_index got=%0d exp=0", regFileWrIndex); end
        total++; if (regFileWrData !== 32'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", regFileWrData); end
        @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic test_mul();
        int lat, writes;
        logic [31:0] data;
        logic [3:0] widx;
        do_op(2'b00, 32'd7, 32'd6, 4'd3, lat, data, widx, writes);
        total++; if (lat != 32) begin bad++; $display("FAIL mul_latency got=%0d exp=32", lat); end
        total++; if (data !== 32'd42) begin bad++; $display("FAIL mul_data got=%0d exp=42", data); end
        total++; if (widx !== 4'd3) begin bad++; $display("FAIL mul_index got=%0d exp=3", widx); end
        total++; if (writes != 1) begin bad++; $display("FAIL mul_writes got=%0d exp=1", writes); end
        total++; if (regFileWrData !== 32'd42 || regFileWrIndex !== 4'd3 || regFileWrEn !== 1'b0) begin
            bad++; $display("FAIL mul_hold got=%0d/%0d/%0b exp=42/3/0", regFileWrData, regFileWrIndex, regFileWrEn);
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mul_idle_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_mul_max();
        int lat, writes;
        logic [31:0] data;
        logic [3:0] widx;
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd0, lat, data, widx, writes);
        total++; if (data !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mulhu_data got=%h exp=fffffffe", data); end
        total++; if (widx !== 4'd0 || writes != 1) begin bad++; $display("FAIL mulhu_idx0 got=%0d/%0d exp=0/1", widx, writes); end
        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd15, lat, data, widx, writes);
        total++; if (data !== 32'h0000_0001) begin bad++; $display("FAIL mullo_data got=%h exp=00000001", data); end
        total++; if (widx !== 4'd15 || lat != 32) begin bad++; $display("FAIL mullo_idx_lat got=%0d/%0d exp=15/32", widx, lat); end
    endtask

    task automatic test_divide();
        int lat, writes;
        logic [31:0] data;
        logic [3:0] widx;
        do_op(2'b10, 32'd100, 32'd7, 4'd4, lat, data, widx, writes);
        total++; if (data !== 32'd14 || lat != 32) begin bad++; $display("FAIL divu_data got=%0d lat=%0d exp=14 lat=32", data, lat); end
        do_op(2'b11, 32'd100, 32'd7, 4'd5, lat, data, widx, writes);
        total++; if (data !== 32'd2 || widx !== 4'd5) begin bad++; $display("FAIL remu_data got=%0d idx=%0d exp=2 idx=5", data, widx); end
        do_op(2'b10, 32'hFFFF_FFFF, 32'd1, 4'd6, lat, data, widx, writes);
        total++; if (data !== 32'hFFFF_FFFF || lat != 32) begin bad++; $display("FAIL divu_max got=%h lat=%0d exp=ffffffff lat=32", data, lat); end
        do_op(2'b11, 32'd12345, 32'd1000, 4'd7, lat, data, widx, writes);
        total++; if (data !== 32'd345 || writes != 1) begin bad++; $display("FAIL remu_mid got=%0d w=%0d exp=345 w=1", data, writes); end
    endtask

    task automatic test_div_zero();
        int lat, writes;
        logic [31:0] data;
        logic [3:0] widx;
        do_op(2'b10, 32'd5, 32'd0, 4'd8, lat, data, widx, writes);
        total++; if (data !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div0_quot got=%h exp=ffffffff", data); end
        total++; if (lat != 1 || writes != 1) begin bad++; $display("FAIL div0_latency got=%0d w=%0d exp=1 w=1", lat, writes); end
        do_op(2'b11, 32'd5, 32'd0, 4'd9, lat, data, widx, writes);
        total++; if (data !== 32'd5 || widx !== 4'd9) begin bad++; $display("FAIL rem0_data got=%0d idx=%0d exp=5 idx=9", data, widx); end
        total++; if (lat != 1) begin bad++; $display("FAIL rem0_latency got=%0d exp=1", lat); end
    endtask

    task automatic test_start_while_busy();
        int lat, writes, early_drop;
        logic [31:0] data;
        logic [3:0] widx;
        lat = -1; writes = 0; early_drop = 0; data = '0; widx = '0;
        @(negedge clk);
        start = 1'b1; op = 2'b00; srcA = 32'd1000; srcB = 32'd1000; dstIndex = 4'd10;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 9) begin
                start = 1'b1; op = 2'b10; srcA = 32'd99; srcB = 32'd3; dstIndex = 4'd11;
            end else begin
                start = 1'b0;
            end
            if (k <= 32 && busy !== 1'b1) early_drop++;
            if (regFileWrEn) begin
                writes++;
                if (lat < 0) begin lat = k; data = regFileWrData; widx = regFileWrIndex; end
            end
        end
        total++; if (data !== 32'd1000000 || widx !== 4'd10) begin bad++; $display("FAIL busy_ignore_data got=%0d idx=%0d exp=1000000 idx=10", data, widx); end
        total++; if (writes != 1 || lat != 32) begin bad++; $display("FAIL busy_ignore_writes got=%0d lat=%0d exp=1 lat=32", writes, lat); end
        total++; if (early_drop != 0) begin bad++; $display("FAIL busy_held got=%0d drops exp=0", early_drop); end
    endtask

    task automatic test_back_to_back();
        int first_k, second_k, writes;
        logic [31:0] d1, d2;
        first_k = -1; second_k = -1; writes = 0; d1 = '0; d2 = '0;
        @(negedge clk);
        start = 1'b1; op = 2'b00; srcA = 32'd2; srcB = 32'd3; dstIndex = 4'd1;
        @(posedge clk);
        @(negedge clk);
        srcA = 32'd5; srcB = 32'd5; dstIndex = 4'd2;
        for (int k = 1; k <= 70; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 40) start = 1'b0;
            if (regFileWrEn) begin
                writes++;
                if (first_k < 0) begin first_k = k; d1 = regFileWrData; end
                else begin second_k = k; d2 = regFileWrData; end
            end
        end
        total++; if (first_k != 32 || d1 !== 32'd6) begin bad++; $display("FAIL b2b_first got=%0d@%0d exp=6@32", d1, first_k); end
        total++; if (second_k != 66 || d2 !== 32'd25 || writes != 2) begin
            bad++; $display("FAIL b2b_second got=%0d@%0d w=%0d exp=25@66 w=2", d2, second_k, writes);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, writes, stray;
        logic [31:0] data;
        logic [3:0] widx;
        stray = 0;
        @(negedge clk);
        start = 1'b1; op = 2'b10; srcA = 32'd1000; srcB = 32'd3; dstIndex = 4'd12;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (regFileWrEn) stray++;
        end
        #2 resetN = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0 || regFileWrEn !== 1'b0) begin
            bad++; $display("FAIL rst_async_ctrl got=%0b%0b%0b exp=000", busy, done, regFileWrEn);
        end
        total++; if (regFileWrData !== 32'd0 || regFileWrIndex !== 4'd0) begin
            bad++; $display("FAIL rst_async_data got=%h/%0d exp=0/0", regFileWrData, regFileWrIndex);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (regFileWrEn) stray++;
        end
        resetN = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (regFileWrEn) stray++;
        end
        total++; if (stray != 0) begin bad++; $display("FAIL rst_no_write got=%0d exp=0", stray); end
        do_op(2'b00, 32'd3, 32'd4, 4'd13, lat, data, widx, writes);
        total++; if (data !== 32'd12 || widx !== 4'd13 || lat != 32) begin
            bad++; $display("FAIL rst_fresh_mul got=%0d idx=%0d lat=%0d exp=12 idx=13 lat=32", data, widx, lat);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_mul();
        test_mul_max();
        test_divide();
        test_div_zero();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
